// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: funct3 codes, FSM
// states and the access-size helper.
package lsu_pkg;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 9;
  localparam int DEPTH  = 256;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_RMW_RD = 3'd2,
    S_WR     = 3'd3,
    S_RESP   = 3'd4
  } lsu_state_e;

  // funct3[1:0] encodes log2 of the access size for every legal code.
  function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
    case (funct3[1:0])
      2'd0:    return 4'd1;
      2'd1:    return 4'd2;
      2'd2:    return 4'd4;
      default: return 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Request/response bus between the execute stage (master) and the
// load/store unit (slave).
interface lsu_if;
  import lsu_pkg::*;

  // A transfer happens on the rising clk edge where valid & ready are both 1;
  // the sender holds valid and its payload stable until that edge, and ready
  // may not depend on anything but the receiver's own state.
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/lsu_align.sv
// Combinational data shaping: load extract/extend from the low bytes of the
// memory word, and store byte-merge into the previously read doubleword.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]        funct3,
  input  logic [DATA_W-1:0] rdata,
  input  logic [DATA_W-1:0] merge,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] load_data,
  output logic [DATA_W-1:0] store_data
);

  always_comb begin
    load_data = rdata;
    case (funct3)
      F3_B:    load_data = {{56{rdata[7]}},  rdata[7:0]};
      F3_H:    load_data = {{48{rdata[15]}}, rdata[15:0]};
      F3_W:    load_data = {{32{rdata[31]}}, rdata[31:0]};
      F3_BU:   load_data = {56'd0, rdata[7:0]};
      F3_HU:   load_data = {48'd0, rdata[15:0]};
      F3_WU:   load_data = {32'd0, rdata[31:0]};
      default: load_data = rdata;
    endcase
  end

  // Stores only ever carry funct3 0..3, so the low two bits pick the size.
  always_comb begin
    store_data = wdata;
    case (funct3[1:0])
      2'd0:    store_data = {merge[63:8],  wdata[7:0]};
      2'd1:    store_data = {merge[63:16], wdata[15:0]};
      2'd2:    store_data = {merge[63:32], wdata[31:0]};
      default: store_data = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RISC-V load/store unit in front of a 64-bit byte-addressed memory that
// always writes 8 bytes; sub-doubleword stores go through read-modify-write.
// Build option MISALIGN_TRAP_EN: reject accesses not aligned to their size.
module load_store_unit
  import lsu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  lsu_if.slave              bus,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output lsu_state_e        dbg_state
);

  lsu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        f3_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] merge_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;

  logic [3:0]        req_size;
  logic [ADDR_W:0]   req_end;
  logic              f3_bad;
  logic              range_bad;
  logic              align_bad;
  logic              req_bad;
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] store_data;

  // Range check is done one bit wider so an access touching byte DEPTH
  // is caught instead of silently wrapping.
  always_comb begin
    req_size  = size_bytes(bus.req_funct3);
    req_end   = {1'b0, bus.req_addr} + (ADDR_W+1)'(req_size);
    f3_bad    = bus.req_we ? bus.req_funct3[2] : (bus.req_funct3 == 3'b111);
    range_bad = req_end > (ADDR_W+1)'(DEPTH);
`ifdef MISALIGN_TRAP_EN
    align_bad = (bus.req_addr & ADDR_W'(req_size - 4'd1)) != '0;
`else
    align_bad = 1'b0;
`endif
    req_bad   = f3_bad | range_bad | align_bad;
  end

  lsu_align u_align (
    .funct3     (f3_q),
    .rdata      (mem_rdata),
    .merge      (merge_q),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .store_data (store_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    mem_we         = 1'b0;
    mem_addr       = '0;
    case (state_q)
      S_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          if (req_bad)                     state_d = S_RESP;
          else if (!bus.req_we)            state_d = S_LOAD;
          else if (bus.req_funct3 == F3_D) state_d = S_WR;
          else                             state_d = S_RMW_RD;
        end
      end
      S_LOAD: begin
        mem_addr = addr_q;
        state_d  = S_RESP;
      end
      S_RMW_RD: begin
        mem_addr = addr_q;
        state_d  = S_WR;
      end
      S_WR: begin
        mem_addr = addr_q;
        mem_we   = 1'b1;
        state_d  = S_RESP;
      end
      S_RESP: begin
        bus.resp_valid = 1'b1;
        if (bus.resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      f3_q    <= '0;
      wdata_q <= '0;
      merge_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (bus.req_valid) begin
          addr_q  <= bus.req_addr;
          f3_q    <= bus.req_funct3;
          wdata_q <= bus.req_wdata;
          rdata_q <= '0;
          err_q   <= req_bad;
        end
        S_LOAD:   rdata_q <= load_data;
        S_RMW_RD: merge_q <= mem_rdata;
        default: ;
      endcase
    end
  end

  assign bus.resp_rdata = (state_q == S_RESP) ? rdata_q : '0;
  assign bus.resp_err   = (state_q == S_RESP) & err_q;
  assign mem_wdata      = store_data;
  assign dbg_state      = state_q;

endmodule
